// File: rtl/fifo_tx_pkg.sv
// Shared types and constants for the burst pattern generator and its LFSR.
package fifo_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_HEAD = 3'd2,
    ST_WORK = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [1:0] PAT_INC   = 2'd0;
  localparam logic [1:0] PAT_ONES  = 2'd1;
  localparam logic [1:0] PAT_LFSR  = 2'd2;
  localparam logic [1:0] PAT_CHOFS = 2'd3;

  // Fibonacci taps 32,22,2,1 expressed as bit positions 31,21,1,0.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic lfsr_feedback(input logic [31:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/fifo_tx_gen_lfsr32.sv
// 32-bit shift-left Fibonacci LFSR; advances one step per cycle while en is high.
module lfsr32
  import fifo_tx_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] q
);

  logic [31:0] q_reg;
  logic [31:0] q_next;

  assign q_next[0] = lfsr_feedback(q_reg);

  for (genvar gi = 1; gi < 32; gi++) begin : g_shift
    assign q_next[gi] = q_reg[gi-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= SEED;
    end else if (en) begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/fifo_tx_gen.sv
// Framed burst generator: one header word then BURST_LEN pattern words per burst,
// channels rotating round-robin, writes stalling while the TX FIFO is full.
module fifo_tx_gen
  import fifo_tx_pkg::*;
#(
  parameter int          DW        = 8,
  parameter int          BURST_LEN = 128,
  parameter int          CH_NUM    = 4,
  parameter int          CHW       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
  parameter logic [7:0]  HDR_TAG   = 8'hF0,
  parameter logic [31:0] SEED      = 32'hACE1_0001
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           full,
  input  logic           fs,
  input  logic [1:0]     mode,
  output logic           fd,
  output logic           fifo_txen,
  output logic [DW-1:0]  fifo_txd,
  output logic [CHW-1:0] ch
);

  localparam int             NW          = $clog2(BURST_LEN + 1);
  localparam logic [NW-1:0]  NUM_LAST    = NW'(BURST_LEN - 1);
  localparam logic [CHW-1:0] CH_LAST     = CHW'(CH_NUM - 1);
  localparam logic [DW-1:0]  HDR_TAG_EXT = DW'(HDR_TAG);

  state_t         state_reg, state_next;
  logic [NW-1:0]  num_reg,   num_next;
  logic [CHW-1:0] ch_reg,    ch_next;
  logic [1:0]     mode_reg,  mode_next;
  logic           lfsr_en;
  logic [31:0]    lfsr_q;
  logic [DW-1:0]  hdr_word;
  logic [DW-1:0]  pat_word;

  lfsr32 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (lfsr_en),
    .q   (lfsr_q)
  );

  // Header: tag with its low CHW bits overwritten by the channel index.
  for (genvar gi = 0; gi < DW; gi++) begin : g_hdr
    if (gi < CHW) begin : g_ch_bit
      assign hdr_word[gi] = ch_reg[gi];
    end else begin : g_tag_bit
      assign hdr_word[gi] = HDR_TAG_EXT[gi];
    end
  end

  always_comb begin
    pat_word = '0;
    case (mode_reg)
      PAT_INC:   pat_word = DW'(32'(num_reg) + 32'd1);
      PAT_ONES:  pat_word = '1;
      PAT_LFSR:  pat_word = DW'(lfsr_q);
      PAT_CHOFS: pat_word = DW'(32'(ch_reg) * 32'(BURST_LEN) + 32'(num_reg) + 32'd1);
      default:   pat_word = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      num_reg   <= '0;
      ch_reg    <= '0;
      mode_reg  <= PAT_INC;
    end else begin
      state_reg <= state_next;
      num_reg   <= num_next;
      ch_reg    <= ch_next;
      mode_reg  <= mode_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    num_next   = num_reg;
    ch_next    = ch_reg;
    mode_next  = mode_reg;
    fifo_txen  = 1'b0;
    fd         = 1'b0;
    lfsr_en    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!full) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (fs) begin
          state_next = ST_HEAD;
          num_next   = '0;
          mode_next  = mode;
        end
      end
      ST_HEAD: begin
        fifo_txen = !full;
        if (!full) state_next = ST_WORK;
      end
      ST_WORK: begin
        fifo_txen = !full;
        if (!full) begin
          num_next = num_reg + NW'(1);
          lfsr_en  = (mode_reg == PAT_LFSR);
          if (num_reg == NUM_LAST) state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        fd = 1'b1;
        // Hold here while the controller still requests, so fd stays a level.
        if (!fs) begin
          state_next = ST_IDLE;
          ch_next    = (ch_reg == CH_LAST) ? '0 : ch_reg + CHW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign fifo_txd = (state_reg == ST_WORK) ? pat_word : hdr_word;
  assign ch       = ch_reg;

endmodule

// File: tb/tb_fifo_tx_gen.sv
// Randomised self-checking bench: each burst's expected words come from a burst-level model.
module tb_fifo_tx_gen;

  localparam int          DW   = 8;
  localparam int          BL   = 4;
  localparam int          CHN  = 4;
  localparam int          CHW  = 2;
  localparam logic [7:0]  TAG  = 8'hF0;
  localparam logic [31:0] SEED = 32'hACE1_0001;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           full = 1'b0;
  logic           fs = 1'b0;
  logic [1:0]     mode = 2'd0;
  logic           fd;
  logic           fifo_txen;
  logic [DW-1:0]  fifo_txd;
  logic [CHW-1:0] ch;

  fifo_tx_gen #(
    .DW(DW), .BURST_LEN(BL), .CH_NUM(CHN), .CHW(CHW), .HDR_TAG(TAG), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .full(full), .fs(fs), .mode(mode),
    .fd(fd), .fifo_txen(fifo_txen), .fifo_txd(fifo_txd), .ch(ch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  // Burst-level model state
  logic [DW-1:0]  pred [0:BL];
  logic [CHW-1:0] pred_ch;
  int             model_ch = 0;
  logic [31:0]    model_lfsr = SEED;
  int             burst_wr = BL + 1;
  int             first_cyc = 0;
  int             last_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic fb;
    fb = s[31] ^ s[21] ^ s[1] ^ s[0];
    return {s[30:0], fb};
  endfunction

  // Fill pred[] with the BL+1 words the next burst must write.
  task automatic predict(input int m);
    pred_ch = CHW'(model_ch);
    pred[0] = DW'(((int'(TAG) >> CHW) << CHW) + model_ch);
    for (int j = 0; j < BL; j++) begin
      case (m)
        0: pred[j+1] = DW'(j + 1);
        1: pred[j+1] = '1;
        2: begin
          pred[j+1]  = model_lfsr[DW-1:0];
          model_lfsr = lfsr_step(model_lfsr);
        end
        default: pred[j+1] = DW'(model_ch * BL + j + 1);
      endcase
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (burst_wr > 0 && burst_wr < BL + 1) begin
          check("txen_vs_full", fifo_txen, !full);
          check("fd_mid_burst", fd, 1'b0);
        end else if (full) begin
          check("txen_when_full", fifo_txen, 1'b0);
        end
        if (fifo_txen) begin
          if (burst_wr > BL) begin
            check("spurious_write", fifo_txen, 1'b0);
          end else begin
            check($sformatf("txd_w%0d", burst_wr), fifo_txd, pred[burst_wr]);
            check("ch_during_burst", ch, pred_ch);
            if (burst_wr == 0) first_cyc = cyc;
            last_cyc = cyc;
            burst_wr++;
          end
        end
      end
    end
  endtask

  task automatic do_burst(input int m, input bit rnd, input bit drop, input int stall_at,
                          input int abort_at, input bit lat);
    int c0;
    int stall_cycles;
    bit stalled;
    int hold;
    predict(m);
    burst_wr = 0;
    mode = 2'(m);
    fs = 1'b1;
    c0 = cyc;
    stalled = 1'b0;
    stall_cycles = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (burst_wr == BL + 1) break;
      if (abort_at >= 0 && burst_wr == abort_at) begin
        rst = 1'b1;
        #1;
        check("rst_async_txen", fifo_txen, 1'b0);
        check("rst_async_fd", fd, 1'b0);
        check("rst_async_ch", ch, '0);
        model_ch = 0;
        model_lfsr = SEED;
        burst_wr = BL + 1;
        fs = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      if (burst_wr > 0) mode = 2'($urandom);
      if (drop && burst_wr >= 2) fs = 1'b0;
      if (rnd) full = ($urandom_range(0, 2) == 0);
      if (stall_at >= 0 && !stalled && burst_wr == stall_at) begin
        full = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        full = 1'b0;
        stalled = 1'b1;
        stall_cycles = 3;
      end
    end
    full = 1'b0;
    check("burst_write_count", burst_wr, BL + 1);
    check("fd_after_burst", fd, 1'b1);
    if (lat) check("header_latency", first_cyc, c0 + 1);
    if (!rnd) check("burst_span", last_cyc - first_cyc, BL + stall_cycles);
    if (!drop) begin
      hold = $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        check("fd_hold", fd, 1'b1);
      end
      fs = 1'b0;
    end
    mode = 2'($urandom);
    @(posedge clk); #1;
    check("fd_clear", fd, 1'b0);
    model_ch = (model_ch + 1) % CHN;
    check("ch_advance", ch, model_ch);
  endtask

  initial begin
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("reset_txen", fifo_txen, 1'b0);
    check("reset_fd", fd, 1'b0);
    check("reset_ch", ch, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Incrementing burst with latency check, pinned words
    do_burst(0, 0, 0, -1, -1, 1);
    check("pin_inc_hdr", pred[0], 8'hF0);
    check("pin_inc_w1", pred[1], 8'h01);
    check("pin_inc_w4", pred[4], 8'h04);

    // Three-cycle stall on num==2
    do_burst(0, 0, 0, 3, -1, 0);

    // All-ones bursts bring the channel back to 0
    do_burst(1, 0, 0, -1, -1, 0);
    check("pin_ones", pred[2], 8'hFF);
    do_burst(1, 0, 0, -1, -1, 0);

    // Channel-offset bursts over all four channels
    for (int b = 0; b < 4; b++) begin
      do_burst(3, 0, 0, -1, -1, 0);
      if (b == 2) begin
        check("pin_chofs_hdr", pred[0], 8'hF2);
        check("pin_chofs_w1", pred[1], 8'h09);
        check("pin_chofs_w4", pred[4], 8'h0C);
      end
    end

    // LFSR bursts, sequence continues across bursts
    do_burst(2, 0, 0, -1, -1, 0);
    check("pin_lfsr_w1", pred[1], 8'h01);
    check("pin_lfsr_w2", pred[2], 8'h03);
    do_burst(2, 0, 0, -1, -1, 0);

    // Reset mid-WORK, then restart from reset values
    do_burst(2, 0, 0, -1, 3, 0);
    do_burst(2, 0, 0, -1, -1, 0);
    check("pin_after_rst_hdr", pred[0], 8'hF0);
    check("pin_after_rst_w1", pred[1], 8'h01);

    // fs dropped mid-burst
    do_burst(0, 0, 1, -1, -1, 0);

    // Randomised bursts with random backpressure and fs drops
    for (int b = 0; b < 30; b++) begin
      do_burst(int'($urandom_range(0, 3)), 1, bit'($urandom_range(0, 1)), -1, -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_tx_gen.md
Name: fifo_tx_gen

Overview:
- Parametrised burst test-pattern generator that writes framed bursts into a downstream TX FIFO.
- Each burst is one header word followed by BURST_LEN payload words in a selectable pattern.
- Bursts rotate round-robin over CH_NUM logical channels.
- Payload writes stall cycle-by-cycle while the FIFO reports full.
- Start/done handshake (fs/fd) towards the frame controller.

Parameters:
- DW, 8, data word width (8..32).
- BURST_LEN, 128, payload words per burst (2..256).
- CH_NUM, 4, number of channels (power of two, 1..16).
- CHW, $clog2(CH_NUM) (min 1), channel index width.
- HDR_TAG, 8'hF0, header marker, zero-extended to DW.
- SEED, 32'hACE1_0001, LFSR reset value (non-zero).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- full  in  1  downstream FIFO full; a write is blocked in the same cycle
- fs  in  1  frame start request, level
- mode  in  2  pattern select, sampled on WAIT->HEAD
- fd  out  1  burst done, level
- fifo_txen  out  1  FIFO write enable
- fifo_txd  out  DW  FIFO write data
- ch  out  CHW  channel of the current/last burst

Behaviour:
- Reset: state=IDLE, num=0, ch=0, lfsr=SEED, mode_r=0, fd=0, fifo_txen=0. fifo_txd is combinational and don't-care while fifo_txen=0.
- A write occurs in a cycle when fifo_txen=1, i.e. wr = (state==HEAD or WORK) & ~full.
- fifo_txen depends combinationally on full; no other combinational input-to-output paths.
- FSM, with registered state and num:
  - IDLE: ~full -> WAIT, else stay.
  - WAIT: fs -> HEAD, num<=0, mode_r<=mode; else stay.
  - HEAD: fifo_txd = HDR_TAG with low CHW bits replaced by ch. On wr -> WORK; else stay, holding the word.
  - WORK: fifo_txd = pattern(num). On wr: num<=num+1. On a write with num==BURST_LEN-1 -> DONE. Without wr, hold num and data.
  - DONE: fd=1. ~fs -> IDLE and ch<=ch+1, wrapping CH_NUM-1 -> 0. If fs stays high, remain in DONE with fd=1 and no writes.
- Patterns, all results truncated modulo 2^DW:
  - mode 0: num+1, giving 1..BURST_LEN.
  - mode 1: all ones.
  - mode 2: lfsr[DW-1:0]. The 32-bit Fibonacci LFSR (taps 32,22,2,1, shift-left, feedback into bit0) advances only on a WORK write in mode 2. It is never reinitialised except by rst, so the sequence continues across bursts.
  - mode 3: ch*BURST_LEN + num + 1.
- Burst timing: exactly BURST_LEN+1 writes per burst. With full=0 throughout, HEAD write is the cycle after WAIT->HEAD, and payload occupies the next BURST_LEN consecutive cycles.
- Boundaries:
  - full asserted in any WORK cycle, including the last word: no write, no progress. This gives an exact resume with no lost or duplicated words.
  - fs dropping mid-burst: ignored; the burst completes, then DONE exits immediately.
  - mode changes mid-burst: ignored (mode_r is used).
  - num width $clog2(BURST_LEN+1); no wrap within a burst.
  - rst mid-burst: immediate return to reset values; the partial burst is abandoned.

Decomposition:
- Shared package fifo_tx_pkg: state encoding (IDLE/WAIT/HEAD/WORK/DONE, 3 bit), mode constants (PAT_INC=0, PAT_ONES=1, PAT_LFSR=2, PAT_CHOFS=3), LFSR tap constant.
- One sub-module, lfsr32: clk, rst, en, seed param, q[31:0].

Test Plan:
- DW=8, BURST_LEN=4, full=0, mode=0, fs pulse held high -> writes F0,01,02,03,04 on 5 consecutive cycles; fd=1 the cycle after; fs low -> IDLE, ch=1.
- Same config, full high for 3 cycles when num=2 -> write sequence unchanged, txen low exactly 3 cycles, total 5 writes.
- Four bursts, mode=3 -> headers F0,F1,F2,F3; burst ch=2 payload 09,0A,0B,0C; ch wraps to 0 after the fourth.
- mode=2, two bursts -> 8 payload words equal the low bytes of 8 consecutive LFSR states from SEED (0x01,...); second burst continues the first.
- rst asserted mid-WORK, then fs -> outputs reset asynchronously; next burst header F0, payload restarts at 01; LFSR back to SEED.
- fs dropped during WORK -> burst still completes with BURST_LEN+1 writes; fd high exactly one cycle.
